// File: rtl/fifo_burst_uart_tx_pkg.sv
// fifo_uart_pkg: shared definitions for the burst FIFO-to-UART sender.
//   - FSM state encodings (plain localparams so legacy tools can read them)
//   - default sync header byte
//   - bytes_of(): number of bytes in a FIFO word
package fifo_uart_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_READ = 3'd2;
  localparam logic [2:0] ST_LAT  = 3'd3;
  localparam logic [2:0] ST_LOAD = 3'd4;
  localparam logic [2:0] ST_SEND = 3'd5;
  localparam logic [2:0] ST_ACK  = 3'd6;
  localparam logic [2:0] ST_WAIT = 3'd7;

  localparam logic [7:0] DEFAULT_HDR_BYTE = 8'hA5;

  function automatic int unsigned bytes_of(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/fifo_burst_uart_tx_if.sv
// fifo_burst_uart_tx_if: FIFO read side and UART transmit side of the burst sender.
//   master modport: the sender (drives fifo_rdreq, tx_*, status pulses)
//   slave modport : the environment (FIFO + UART, drives flags, data, tx_busy)
interface fifo_burst_uart_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_q;
  logic              fifo_rdreq;
  logic              tx_busy;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              active;
  logic              burst_done;
  logic              underflow;

  modport master (
    input  fifo_full, fifo_empty, fifo_q, tx_busy,
    output fifo_rdreq, tx_data, tx_start, active, burst_done, underflow
  );

  modport slave (
    output fifo_full, fifo_empty, fifo_q, tx_busy,
    input  fifo_rdreq, tx_data, tx_start, active, burst_done, underflow
  );

endinterface

// File: rtl/fifo_burst_uart_tx_byte_serializer.sv
// byte_serializer: holds one FIFO word and presents it a byte at a time, LSB first.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture load_data, restart at byte 0, clear header flag
//   load_data  : FIFO word
//   hdr_load   : capture hdr_byte as a one-byte "word" and set the header flag
//   hdr_byte   : sync header value
//   shift      : advance to the next byte
//   byte_out   : current byte
//   last       : current byte is the last byte of the word
//   is_hdr     : current content is the header byte
module byte_serializer
  import fifo_uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              hdr_load,
  input  logic [7:0]        hdr_byte,
  input  logic              shift,
  output logic [7:0]        byte_out,
  output logic              last,
  output logic              is_hdr
);

  localparam int unsigned BYTES = bytes_of(DATA_W);
  localparam int unsigned IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_W-1:0] shift_q;
  logic [IW-1:0]     byte_idx_q;
  logic              hdr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
      hdr_q      <= 1'b0;
    end else if (load) begin
      shift_q    <= load_data;
      byte_idx_q <= '0;
      hdr_q      <= 1'b0;
    end else if (hdr_load) begin
      shift_q    <= DATA_W'(hdr_byte);
      byte_idx_q <= '0;
      hdr_q      <= 1'b1;
    end else if (shift) begin
      shift_q    <= shift_q >> 8;
      byte_idx_q <= byte_idx_q + IW'(1);
    end
  end

  assign byte_out = shift_q[7:0];
  assign last     = (byte_idx_q == IW'(BYTES - 1));
  assign is_hdr   = hdr_q;

endmodule

// File: rtl/fifo_burst_uart_tx.sv
// fifo_burst_uart_tx: when the capture FIFO is full, reads BURST_LEN words and sends each
// word to the UART transmitter as DATA_W/8 bytes, LSB first, one tx_start per byte.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fifo_burst_uart_tx_if.master
//              fifo_full/fifo_empty/fifo_q/fifo_rdreq : FIFO read port (registered latency)
//              tx_busy/tx_data/tx_start               : UART transmitter handshake
//              active/burst_done/underflow            : status
// Optional build macro BURST_HEADER_EN: send HDR_BYTE before the first word of each burst.
module fifo_burst_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 512,
  parameter int unsigned RD_LAT    = 2,
  parameter logic [7:0]  HDR_BYTE  = DEFAULT_HDR_BYTE
) (
  input logic                  clk,
  input logic                  rst,
  fifo_burst_uart_tx_if.master bus
);

  localparam int unsigned WCW = $clog2(BURST_LEN + 1);

  if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_bad_data_w
    $error("DATA_W must be a non-zero multiple of 8");
  end
  if (BURST_LEN < 1 || BURST_LEN > 65535) begin : g_bad_burst_len
    $error("BURST_LEN must be in 1..65535");
  end
  if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
    $error("RD_LAT must be in 1..7");
  end

  logic [2:0]     state_q, state_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d, word_cnt_inc;
  logic [2:0]     lat_cnt_q, lat_cnt_d;
  logic           rdreq_q, rdreq_d;
  logic           tx_start_q, tx_start_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           done_q, done_d;
  logic           uf_q, uf_d;
  logic           active_q;

  logic       ser_load, ser_hdr_load, ser_shift;
  logic [7:0] ser_byte;
  logic       ser_last, ser_is_hdr;

  byte_serializer #(
    .DATA_W(DATA_W)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .load_data(bus.fifo_q),
    .hdr_load (ser_hdr_load),
    .hdr_byte (HDR_BYTE),
    .shift    (ser_shift),
    .byte_out (ser_byte),
    .last     (ser_last),
    .is_hdr   (ser_is_hdr)
  );

  assign word_cnt_inc = word_cnt_q + WCW'(1);

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    rdreq_d      = 1'b0;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    done_d       = 1'b0;
    uf_d         = 1'b0;
    ser_load     = 1'b0;
    ser_hdr_load = 1'b0;
    ser_shift    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.fifo_full) begin
          word_cnt_d = '0;
`ifdef BURST_HEADER_EN
          state_d    = ST_HDR;
`else
          state_d    = ST_READ;
`endif
        end
      end
`ifdef BURST_HEADER_EN
      ST_HDR: begin
        ser_hdr_load = 1'b1;
        state_d      = ST_SEND;
      end
`endif
      ST_READ: begin
        if (bus.fifo_empty) begin
          uf_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          // rdreq is registered, so the strobe is seen during the first LAT cycle;
          // LAT therefore lasts RD_LAT cycles so LOAD lines up with valid fifo_q.
          rdreq_d   = 1'b1;
          lat_cnt_d = 3'(RD_LAT - 1);
          state_d   = ST_LAT;
        end
      end
      ST_LAT: begin
        if (lat_cnt_q == 3'd0) begin
          state_d = ST_LOAD;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      ST_LOAD: begin
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        tx_data_d  = ser_byte;
        tx_start_d = 1'b1;
        state_d    = ST_ACK;
      end
      // tx_busy only rises the cycle after tx_start; ACK keeps WAIT from seeing stale idle.
      ST_ACK: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!bus.tx_busy) begin
          if (ser_is_hdr) begin
            state_d = ST_READ;
          end else if (!ser_last) begin
            ser_shift = 1'b1;
            state_d   = ST_SEND;
          end else begin
            word_cnt_d = word_cnt_inc;
            if (word_cnt_inc == WCW'(BURST_LEN)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_READ;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      lat_cnt_q  <= '0;
      rdreq_q    <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
      uf_q       <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      rdreq_q    <= rdreq_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
      uf_q       <= uf_d;
      active_q   <= (state_d != ST_IDLE);
    end
  end

  assign bus.fifo_rdreq = rdreq_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.burst_done = done_q;
  assign bus.underflow  = uf_q;
  assign bus.active     = active_q;

endmodule

// File: tb/tb_fifo_burst_uart_tx.sv
// Bench for fifo_burst_uart_tx: two instances (8-bit words / 32-bit words) each with a
// registered-latency FIFO model and a UART model whose busy time is programmable.
module tb_fifo_burst_uart_tx;

  localparam int unsigned RL_A = 2;
  localparam int unsigned RL_B = 3;
  localparam int TMO = 5000;
`ifdef BURST_HEADER_EN
  localparam int HN = 1;
`else
  localparam int HN = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  fifo_burst_uart_tx_if #(.DATA_W(8))  ifa ();
  fifo_burst_uart_tx_if #(.DATA_W(32)) ifb ();

  fifo_burst_uart_tx #(
    .DATA_W   (8),
    .BURST_LEN(4),
    .RD_LAT   (RL_A),
    .HDR_BYTE (8'hA5)
  ) u_dut_a (
    .clk(clk),
    .rst(rst_a),
    .bus(ifa)
  );

  fifo_burst_uart_tx #(
    .DATA_W   (32),
    .BURST_LEN(2),
    .RD_LAT   (RL_B),
    .HDR_BYTE (8'hA5)
  ) u_dut_b (
    .clk(clk),
    .rst(rst_b),
    .bus(ifb)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- environment A ----------------
  logic [7:0] mem_a [64];
  int         rd_cnt_a = 0;
  logic [7:0] hist_a = '0;
  logic [7:0] rqv_a;
  int         busy_len_a = 5;
  int         bcnt_a = 0;
  logic [7:0] cap_a [256];
  int         scyc_a [256];
  int         ncap_a = 0, rq_a = 0, done_a = 0, uf_a = 0;

  assign rqv_a = {hist_a[6:0], ifa.fifo_rdreq};
  assign ifa.tx_busy = (bcnt_a != 0);

  always @(posedge clk) begin
    hist_a <= rqv_a;
    if (rqv_a[RL_A-1]) begin
      ifa.fifo_q <= mem_a[rd_cnt_a % 64];
      rd_cnt_a   <= rd_cnt_a + 1;
    end
    if (ifa.fifo_rdreq) rq_a <= rq_a + 1;
    if (ifa.burst_done) done_a <= done_a + 1;
    if (ifa.underflow) uf_a <= uf_a + 1;
    if (ifa.tx_start) begin
      bcnt_a                <= busy_len_a;
      cap_a[ncap_a % 256]   <= ifa.tx_data;
      scyc_a[ncap_a % 256]  <= cyc;
      ncap_a                <= ncap_a + 1;
    end else if (bcnt_a > 0) begin
      bcnt_a <= bcnt_a - 1;
    end
  end

  // ---------------- environment B ----------------
  logic [31:0] mem_b [64];
  int          rd_cnt_b = 0;
  logic [7:0]  hist_b = '0;
  logic [7:0]  rqv_b;
  int          busy_len_b = 5;
  int          bcnt_b = 0;
  logic [7:0]  cap_b [256];
  int          scyc_b [256];
  int          ncap_b = 0, rq_b = 0, done_b = 0, uf_b = 0;

  assign rqv_b = {hist_b[6:0], ifb.fifo_rdreq};
  assign ifb.tx_busy = (bcnt_b != 0);

  always @(posedge clk) begin
    hist_b <= rqv_b;
    if (rqv_b[RL_B-1]) begin
      ifb.fifo_q <= mem_b[rd_cnt_b % 64];
      rd_cnt_b   <= rd_cnt_b + 1;
    end
    if (ifb.fifo_rdreq) rq_b <= rq_b + 1;
    if (ifb.burst_done) done_b <= done_b + 1;
    if (ifb.underflow) uf_b <= uf_b + 1;
    if (ifb.tx_start) begin
      bcnt_b                <= busy_len_b;
      cap_b[ncap_b % 256]   <= ifb.tx_data;
      scyc_b[ncap_b % 256]  <= cyc;
      ncap_b                <= ncap_b + 1;
    end else if (bcnt_b > 0) begin
      bcnt_b <= bcnt_b - 1;
    end
  end

  // ---------------- checking ----------------
  logic [7:0] exp_b8 [8];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cnt_sel(input int sel);
    case (sel)
      0:       return done_a;
      1:       return uf_a;
      2:       return ncap_a;
      3:       return rq_a;
      4:       return done_b;
      default: return ncap_b;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int target, input string tag);
    int n = 0;
    while (cnt_sel(sel) < target && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_timeout"}, 64'(n < TMO), 64'd1);
  endtask

  // Compares captured bytes (after the optional header) against exp_b8[0..n-1].
  task automatic check_seq(input bit is_b, input int base, input int n, input string tag);
    logic [7:0] g;
`ifdef BURST_HEADER_EN
    g = is_b ? cap_b[base % 256] : cap_a[base % 256];
    check_eq({tag, "_hdr"}, 64'(g), 64'hA5);
`endif
    for (int i = 0; i < n; i++) begin
      g = is_b ? cap_b[(base + HN + i) % 256] : cap_a[(base + HN + i) % 256];
      check_eq($sformatf("%s_byte%0d", tag, i), 64'(g), 64'(exp_b8[i]));
    end
  endtask

  initial begin
    int q0, c0, d0, u0;
    ifa.fifo_full  = 1'b0;
    ifa.fifo_empty = 1'b0;
    ifb.fifo_full  = 1'b0;
    ifb.fifo_empty = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of both instances.
    check_eq("rst_a_outs", {ifa.active, ifa.tx_start, ifa.fifo_rdreq, ifa.burst_done,
                            ifa.underflow, ifa.tx_data}, 64'd0);
    check_eq("rst_b_outs", {ifb.active, ifb.tx_start, ifb.fifo_rdreq, ifb.burst_done,
                            ifb.underflow, ifb.tx_data}, 64'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_a_active", 64'(ifa.active), 64'd0);

    // T1: 8-bit words 11,22,33,44, busy 5 cycles per byte.
    exp_b8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) mem_a[(rd_cnt_a + i) % 64] = exp_b8[i];
    q0 = rq_a; c0 = ncap_a; d0 = done_a; u0 = uf_a;
    ifa.fifo_full = 1'b1;
    @(negedge clk);
    ifa.fifo_full = 1'b0;
    check_eq("t1_active", 64'(ifa.active), 64'd1);
    wait_for(0, d0 + 1, "t1_done");
    repeat (3) @(negedge clk);
    check_eq("t1_rdreq_cnt", 64'(rq_a - q0), 64'd4);
    check_eq("t1_start_cnt", 64'(ncap_a - c0), 64'(4 + HN));
    check_eq("t1_done_cnt", 64'(done_a - d0), 64'd1);
    check_eq("t1_uf_cnt", 64'(uf_a - u0), 64'd0);
    check_eq("t1_idle", 64'(ifa.active), 64'd0);
    check_seq(1'b0, c0, 4, "t1");

    // T3: empty before the third word's READ -> two words out, one underflow.
    exp_b8 = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) mem_a[(rd_cnt_a + i) % 64] = exp_b8[i];
    q0 = rq_a; c0 = ncap_a; d0 = done_a; u0 = uf_a;
    ifa.fifo_full = 1'b1;
    @(negedge clk);
    ifa.fifo_full = 1'b0;
    wait_for(3, q0 + 2, "t3_two_reads");
    ifa.fifo_empty = 1'b1;
    wait_for(1, u0 + 1, "t3_uf");
    repeat (3) @(negedge clk);
    check_eq("t3_rdreq_cnt", 64'(rq_a - q0), 64'd2);
    check_eq("t3_start_cnt", 64'(ncap_a - c0), 64'(2 + HN));
    check_eq("t3_uf_cnt", 64'(uf_a - u0), 64'd1);
    check_eq("t3_done_cnt", 64'(done_a - d0), 64'd0);
    check_eq("t3_idle", 64'(ifa.active), 64'd0);
    check_seq(1'b0, c0, 2, "t3");
    ifa.fifo_empty = 1'b0;

    // T5: reset while waiting on word 2's byte, then a fresh full burst.
    for (int i = 0; i < 4; i++) mem_a[(rd_cnt_a + i) % 64] = 8'hC1 + 8'(i);
    c0 = ncap_a;
    ifa.fifo_full = 1'b1;
    @(negedge clk);
    ifa.fifo_full = 1'b0;
    wait_for(2, c0 + HN + 2, "t5_word2_sent");
    check_eq("t5_pre_active", 64'(ifa.active), 64'd1);
    rst_a = 1'b1;
    @(negedge clk);
    check_eq("t5_rst_outs", {ifa.active, ifa.tx_start, ifa.fifo_rdreq, ifa.burst_done,
                             ifa.underflow, ifa.tx_data}, 64'd0);
    rst_a = 1'b0;
    exp_b8 = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) mem_a[(rd_cnt_a + i) % 64] = exp_b8[i];
    q0 = rq_a; c0 = ncap_a; d0 = done_a;
    ifa.fifo_full = 1'b1;
    @(negedge clk);
    ifa.fifo_full = 1'b0;
    wait_for(0, d0 + 1, "t5_done");
    repeat (2) @(negedge clk);
    check_eq("t5_rdreq_cnt", 64'(rq_a - q0), 64'd4);
    check_eq("t5_start_cnt", 64'(ncap_a - c0), 64'(4 + HN));
    check_seq(1'b0, c0, 4, "t5");

    // T2: 32-bit words, little-endian byte order.
    mem_b[rd_cnt_b % 64]       = 32'hDDCCBBAA;
    mem_b[(rd_cnt_b + 1) % 64] = 32'h44332211;
    exp_b8 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    q0 = rq_b; c0 = ncap_b; d0 = done_b;
    ifb.fifo_full = 1'b1;
    @(negedge clk);
    ifb.fifo_full = 1'b0;
    wait_for(4, d0 + 1, "t2_done");
    repeat (2) @(negedge clk);
    check_eq("t2_rdreq_cnt", 64'(rq_b - q0), 64'd2);
    check_eq("t2_start_cnt", 64'(ncap_b - c0), 64'(8 + HN));
    check_eq("t2_uf_cnt", 64'(uf_b), 64'd0);
    check_seq(1'b1, c0, 8, "t2");

    // T4: tx_busy never asserted -> starts 3 cycles apart inside a word.
    busy_len_b = 0;
    repeat (10) @(negedge clk);
    mem_b[rd_cnt_b % 64]       = 32'h87654321;
    mem_b[(rd_cnt_b + 1) % 64] = 32'h0FEDCBA9;
    exp_b8 = '{8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB, 8'hED, 8'h0F};
    q0 = rq_b; c0 = ncap_b; d0 = done_b;
    ifb.fifo_full = 1'b1;
    @(negedge clk);
    ifb.fifo_full = 1'b0;
    wait_for(4, d0 + 1, "t4_done");
    repeat (2) @(negedge clk);
    check_eq("t4_rdreq_cnt", 64'(rq_b - q0), 64'd2);
    check_seq(1'b1, c0, 8, "t4");
    for (int w = 0; w < 2; w++) begin
      for (int j = 0; j < 3; j++) begin
        int k;
        k = c0 + HN + w * 4 + j;
        check_eq($sformatf("t4_gap_w%0d_b%0d", w, j),
                 64'(scyc_b[(k + 1) % 256] - scyc_b[k % 256]), 64'd3);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
